seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver_if.sv | 26 ++
 rtl/seg_scan_driver.sv | 115 +++++++++++
 tb/tb_seg_scan_driver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Scan-driver bundle: enable/message/load in; anodes, digit code, index and frame pulse out.
// No handshake: inputs are sampled every clkdv edge, outputs are registered.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                         enable;
  logic [NUM_DIGITS*DATA_W-1:0] msg;
  logic                         msg_load;
  logic [NUM_DIGITS-1:0]        an;
  logic [DATA_W-1:0]            out;
  logic [IDX_W-1:0]             digit_idx;
  logic                         frame_start;

  modport master (
    output enable, msg, msg_load,
    input  an, out, digit_idx, frame_start
  );

  modport slave (
    input  enable, msg, msg_load,
    output an, out, digit_idx, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Blank-then-on multi-digit 7-seg scanner with frame-boundary message swap; outputs registered, 1 edge latency.
// No backpressure; SEG_SCAN_LZB_EN adds leading-zero blanking of anodes.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYC     = 1,
  parameter int BLANK_CYC  = 3
) (
  input  logic             clkdv,
  input  logic             reset,
  seg_scan_driver_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MSG_W   = NUM_DIGITS * DATA_W;
  localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TMR_W-1:0] ON_LOAD    = TMR_W'(ON_CYC - 1);
  localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                state;
  logic [TMR_W-1:0]      tmr;
  logic [MSG_W-1:0]      pending;
  logic [MSG_W-1:0]      active;
  logic [MSG_W-1:0]      frame_msg;
  logic [IDX_W-1:0]      next_idx;
  logic [DATA_W-1:0]     next_code;
  logic [NUM_DIGITS-1:0] on_an;
  logic                  tmr_done;
  logic                  start_frame;
  logic                  step_digit;
  logic                  go_on;

  always_comb begin
    // A load on the frame-start edge bypasses the pending buffer.
    frame_msg   = bus.msg_load ? bus.msg : pending;
    tmr_done    = (tmr == '0);
    next_idx    = (bus.digit_idx == '0) ? LAST_IDX : bus.digit_idx - IDX_W'(1);
    next_code   = active[next_idx*DATA_W +: DATA_W];
    start_frame = bus.enable &&
                  ((state == IDLE) || ((state == ON) && tmr_done && (bus.digit_idx == '0)));
    step_digit  = bus.enable && (state == ON) && tmr_done && (bus.digit_idx != '0);
    go_on       = bus.enable && (state == BLANK) && tmr_done;
  end

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  // lead_zero[k]: digit k and every digit to its left are zero.
  always_comb begin
    logic zero_so_far;
    zero_so_far = 1'b1;
    lead_zero   = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_so_far  = zero_so_far && (active[k*DATA_W +: DATA_W] == '0);
      lead_zero[k] = zero_so_far;
    end
  end

  always_comb begin
    on_an = '1;
    if ((bus.digit_idx == '0) || !lead_zero[bus.digit_idx])
      on_an[bus.digit_idx] = 1'b0;
  end
`else
  always_comb begin
    on_an                = '1;
    on_an[bus.digit_idx] = 1'b0;
  end
`endif

  always_ff @(posedge clkdv or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      tmr             <= '0;
      pending         <= '0;
      active          <= '0;
      bus.an          <= '1;
      bus.out         <= '0;
      bus.digit_idx   <= LAST_IDX;
      bus.frame_start <= 1'b0;
    end else begin
      if (bus.msg_load)
        pending <= bus.msg;
      bus.frame_start <= start_frame;

      if (!bus.enable) begin
        state  <= IDLE;
        bus.an <= '1;
      end else if (start_frame) begin
        state         <= BLANK;
        tmr           <= BLANK_LOAD;
        active        <= frame_msg;
        bus.an        <= '1;
        bus.out       <= frame_msg[MSG_W-1 -: DATA_W];
        bus.digit_idx <= LAST_IDX;
      end else if (step_digit) begin
        state         <= BLANK;
        tmr           <= BLANK_LOAD;
        bus.an        <= '1;
        bus.out       <= next_code;
        bus.digit_idx <= next_idx;
      end else if (go_on) begin
        state  <= ON;
        tmr    <= ON_LOAD;
        bus.an <= on_an;
      end else begin
        tmr <= tmr - TMR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: default 4-digit instance driven through directed frames with a
// per-edge expectation queue, plus a 6-digit ON=2/BLANK=1 instance checked for lit-digit counts.
module tb_seg_scan_driver;
  logic clkdv = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clkdv = ~clkdv;

  seg_scan_driver_if #(.NUM_DIGITS(4), .DATA_W(4)) bus ();
  seg_scan_driver_if #(.NUM_DIGITS(6), .DATA_W(4)) bus6 ();

  seg_scan_driver #(.NUM_DIGITS(4), .DATA_W(4), .ON_CYC(1), .BLANK_CYC(3)) dut (
    .clkdv (clkdv),
    .reset (reset),
    .bus   (bus)
  );

  seg_scan_driver #(.NUM_DIGITS(6), .DATA_W(4), .ON_CYC(2), .BLANK_CYC(1)) dut6 (
    .clkdv (clkdv),
    .reset (reset),
    .bus   (bus6)
  );

  typedef struct {
    logic [3:0] an;
    logic [3:0] out;
    logic       fs;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] m, input int d);
    return m[d*4 +: 4];
  endfunction

  // Anode pattern for digit d's ON window given the message shown this frame.
  function automatic logic [3:0] an_exp(input logic [15:0] m, input int d);
    logic lit;
    lit = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    if (d > 0 && (m >> (d*4)) == 16'h0) lit = 1'b0;
`endif
    return lit ? ~(4'b0001 << d) : 4'hF;
  endfunction

  task automatic expect_edge(input logic [3:0] an, input logic [3:0] out,
                             input logic fs, input logic [1:0] idx);
    exp_t e;
    e.an = an; e.out = out; e.fs = fs; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clkdv);
    #1;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_an"},  bus.an,          e.an);
      chk({tag, "_out"}, bus.out,         e.out);
      chk({tag, "_fs"},  bus.frame_start, e.fs);
      chk({tag, "_idx"}, bus.digit_idx,   e.idx);
    end
  endtask

  // n edges of a frame showing `shown`; optional msg_load on edge load_at.
  task automatic run_frame(input logic [15:0] shown, input int n, input int load_at,
                           input logic [15:0] load_val, input string tag);
    int d;
    int pos;
    for (int e = 1; e <= n; e++) begin
      d   = 3 - (e - 1) / 4;
      pos = (e - 1) % 4;
      if (e == load_at) begin
        bus.msg      = load_val;
        bus.msg_load = 1'b1;
      end
      expect_edge((pos == 3) ? an_exp(shown, d) : 4'hF, nib(shown, d), e == 1, d[1:0]);
      tick($sformatf("%s_e%0d", tag, e));
      bus.msg_load = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int lows[6];
    int multi;
    int fs_extra;

    bus.enable    = 1'b0;
    bus.msg       = 16'h1234;
    bus.msg_load  = 1'b1;
    bus6.enable   = 1'b0;
    bus6.msg      = '0;
    bus6.msg_load = 1'b0;

    #1 reset = 1'b1;
    #1;
    chk("rst_an",  bus.an,          4'hF);
    chk("rst_out", bus.out,         4'h0);
    chk("rst_idx", bus.digit_idx,   2'd3);
    chk("rst_fs",  bus.frame_start, 1'b0);
    #1 reset = 1'b0;

    // Load one edge before enabling; stays dark.
    expect_edge(4'hF, 4'h0, 1'b0, 2'd3);
    tick("idle_load");
    bus.msg_load = 1'b0;
    bus.enable   = 1'b1;

    run_frame(16'h1234, 16, 0, 16'h0, "f1");
    run_frame(16'h1234, 16, 0, 16'h0, "f2");
    run_frame(16'h1234, 16, 6, 16'hABCD, "f3_midload");
    run_frame(16'hABCD, 16, 0, 16'h0, "f4");
    run_frame(16'h5678, 16, 1, 16'h5678, "f5_bypass");

    // Drop enable right after digit 2's ON edge; loads still land in pending.
    run_frame(16'h5678, 8, 0, 16'h0, "f6_partial");
    bus.enable   = 1'b0;
    bus.msg      = 16'h9ABC;
    bus.msg_load = 1'b1;
    expect_edge(4'hF, 4'h6, 1'b0, 2'd2);
    tick("dis0");
    bus.msg_load = 1'b0;
    for (int i = 1; i < 4; i++) begin
      expect_edge(4'hF, 4'h6, 1'b0, 2'd2);
      tick($sformatf("dis%0d", i));
    end
    bus.enable = 1'b1;

    // Re-enable restarts a frame; then reset asynchronously mid-ON of digit 1.
    run_frame(16'h9ABC, 12, 0, 16'h0, "f7_reen");
    #2 reset = 1'b1;
    #1;
    chk("midrst_an",  bus.an,          4'hF);
    chk("midrst_out", bus.out,         4'h0);
    chk("midrst_fs",  bus.frame_start, 1'b0);
    chk("midrst_idx", bus.digit_idx,   2'd3);
    #1 reset = 1'b0;

    // Buffers were cleared by reset.
    run_frame(16'h0000, 16, 0, 16'h0, "f8_after_rst");
    bus.enable = 1'b0;

    // 6-digit instance, ON=2, BLANK=1.
    bus6.msg      = 24'h000042;
    bus6.msg_load = 1'b1;
    @(posedge clkdv);
    #1;
    bus6.msg_load = 1'b0;
    bus6.enable   = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge clkdv);
      #1;
      if (bus6.frame_start) found = 1'b1;
    end
    chk("b_fs_found", 32'(found), 32'd1);
    chk("b_fs_out", bus6.out, 4'h0);

    multi    = 0;
    fs_extra = 0;
    for (int i = 0; i < 6; i++) lows[i] = 0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) begin
        @(posedge clkdv);
        #1;
        if (bus6.frame_start) fs_extra++;
      end
      for (int i = 0; i < 6; i++)
        if (bus6.an[i] == 1'b0) lows[i]++;
      if ($countones(~bus6.an) > 1) multi++;
    end
    @(posedge clkdv);
    #1;
    chk("b_period_fs", bus6.frame_start, 1'b1);
    chk("b_fs_extra",  fs_extra, 0);
    chk("b_multi_low", multi,    0);
    for (int i = 0; i < 6; i++) begin
`ifdef SEG_SCAN_LZB_EN
      chk($sformatf("b_lows%0d", i), lows[i], (i >= 2) ? 0 : 2);
`else
      chk($sformatf("b_lows%0d", i), lows[i], 2);
`endif
    end
    bus6.enable = 1'b0;

    if (n_fail != 0) $display("%0d checks did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
